// File: rtl/rv_plic_gw_pkg.sv
// rv_plic_gw_pkg: shared state encoding for the PLIC interrupt gateway.
package rv_plic_gw_pkg;
    typedef enum logic [1:0] {
        GwIdle   = 2'd0,
        GwPend   = 2'd1,
        GwActive = 2'd2
    } gw_state_e;
    localparam gw_state_e GwResetState = GwIdle;
endpackage

// File: rtl/rv_plic_gw_src.sv
// rv_plic_gw_src: single-source gateway FSM with edge detect and stored-edge state.
// RV_PLIC_GW_EDGE_CNT_EN selects a saturating edge counter instead of one sticky bit.
module rv_plic_gw_src
    import rv_plic_gw_pkg::*;
`ifdef RV_PLIC_GW_EDGE_CNT_EN
#(
    parameter int CntWidth = 4
)
`endif
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic src_i,
    input  logic le_i,
    input  logic claim_i,
    input  logic complete_i,
    output logic ip_o,
    output logic ia_o
);
    gw_state_e state_q, state_d;
    logic src_q, set, done, inc, dec, has_stored;
    assign set  = le_i ? (src_i & ~src_q) : src_i;
    assign done = (state_q == GwActive) & complete_i;
    // an edge on the completion cycle re-pends directly rather than being stored
    assign inc  = le_i & set & (state_q != GwIdle) & ~done;
    assign dec  = done & ~set & has_stored;
    always_comb begin
        state_d = (state_q == GwIdle)   ? (set ? GwPend : GwIdle) :
                  (state_q == GwPend)   ? (claim_i ? GwActive : GwPend) :
                  (state_q == GwActive) ? (complete_i ? ((set | has_stored) ? GwPend : GwIdle) : GwActive) :
                  GwResetState;
    end
`ifdef RV_PLIC_GW_EDGE_CNT_EN
    logic [CntWidth-1:0] cnt_q, cnt_d;
    assign has_stored = |cnt_q;
    always_comb begin
        cnt_d = !le_i ? '0 :
                (inc && !(&cnt_q)) ? cnt_q + CntWidth'(1) :
                dec ? cnt_q - CntWidth'(1) : cnt_q;
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
`else
    logic stored_q;
    assign has_stored = stored_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) stored_q <= 1'b0;
        else stored_q <= le_i & (inc | (stored_q & ~dec));
    end
`endif
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= GwResetState;
            src_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_i;
        end
    end
    assign ip_o = (state_q == GwPend);
    assign ia_o = (state_q == GwActive);
endmodule

// File: rtl/rv_plic_gateway_fsm.sv
// rv_plic_gateway_fsm: per-source interrupt gateways with claim/complete id decode.
// Define RV_PLIC_GW_EDGE_CNT_EN to count stored edges (CntWidth bits) instead of one sticky bit.
module rv_plic_gateway_fsm
    import rv_plic_gw_pkg::*;
#(
    parameter int N_SOURCE = 32,
`ifdef RV_PLIC_GW_EDGE_CNT_EN
    parameter int CntWidth = 4,
`endif
    localparam int SrcWidth = $clog2(N_SOURCE)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [N_SOURCE-1:0] src_i,
    input  logic [N_SOURCE-1:0] le_i,
    input  logic                claim_i,
    input  logic [SrcWidth-1:0] claim_id_i,
    input  logic                complete_i,
    input  logic [SrcWidth-1:0] complete_id_i,
    output logic [N_SOURCE-1:0] ip_o,
    output logic [N_SOURCE-1:0] ia_o
);
    // ids >= N_SOURCE match no instance and are therefore ignored
    for (genvar k = 0; k < N_SOURCE; k++) begin : g_src
        rv_plic_gw_src
`ifdef RV_PLIC_GW_EDGE_CNT_EN
        #(.CntWidth(CntWidth))
`endif
        u_src (
            .clk_i      (clk_i),
            .rst_ni     (rst_ni),
            .src_i      (src_i[k]),
            .le_i       (le_i[k]),
            .claim_i    (claim_i && claim_id_i == SrcWidth'(k)),
            .complete_i (complete_i && complete_id_i == SrcWidth'(k)),
            .ip_o       (ip_o[k]),
            .ia_o       (ia_o[k])
        );
    end
endmodule

// File: tb/tb_rv_plic_gateway_fsm.sv
// tb_rv_plic_gateway_fsm: vector table, directed corner sequences and random traffic vs a reference model.
module tb_rv_plic_gateway_fsm;
    localparam int N = 24;
    localparam int W = $clog2(N);
`ifdef RV_PLIC_GW_EDGE_CNT_EN
    localparam int MAXC = 15;
`else
    localparam int MAXC = 1;
`endif
    logic clk_i = 1'b0, rst_ni = 1'b0;
    logic [N-1:0] src_i = '0, le_i = '0;
    logic claim_i = 1'b0, complete_i = 1'b0;
    logic [W-1:0] claim_id_i = '0, complete_id_i = '0;
    logic [N-1:0] ip_o, ia_o;
    int checks = 0, errors = 0;
    int st[N];
    int cnt[N];
    bit prev[N];

    typedef struct {
        logic [N-1:0] src;
        bit           cl;
        int           cl_id;
        bit           cp;
        int           cp_id;
        logic [N-1:0] ip;
        logic [N-1:0] ia;
    } vec_t;
    vec_t vecs[11];

    always #5 clk_i = ~clk_i;

    rv_plic_gateway_fsm #(.N_SOURCE(N)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .src_i         (src_i),
        .le_i          (le_i),
        .claim_i       (claim_i),
        .claim_id_i    (claim_id_i),
        .complete_i    (complete_i),
        .complete_id_i (complete_id_i),
        .ip_o          (ip_o),
        .ia_o          (ia_o)
    );

    function automatic vec_t mk(int s, bit cl, int cid, bit cp, int pid, int ip, int ia);
        vec_t v;
        v.src = N'(s); v.cl = cl; v.cl_id = cid; v.cp = cp; v.cp_id = pid;
        v.ip = N'(ip); v.ia = N'(ia);
        return v;
    endfunction

    // states: 0 idle, 1 pending, 2 in service; cnt = remembered edges awaiting re-pend
    task automatic model_reset();
        for (int k = 0; k < N; k++) begin st[k] = 0; cnt[k] = 0; prev[k] = 0; end
    endtask

    task automatic model_update();
        for (int k = 0; k < N; k++) begin
            bit rise, s, cl, cp;
            rise = src_i[k] && !prev[k];
            s    = le_i[k] ? rise : src_i[k];
            cl   = claim_i && int'(claim_id_i) == k;
            cp   = complete_i && int'(complete_id_i) == k;
            if (st[k] == 0) begin
                if (s) st[k] = 1;
            end else if (st[k] == 1) begin
                if (le_i[k] && rise) cnt[k] = (cnt[k] < MAXC) ? cnt[k] + 1 : MAXC;
                if (cl) st[k] = 2;
            end else if (cp) begin
                if (s) st[k] = 1;
                else if (cnt[k] > 0) begin cnt[k] = cnt[k] - 1; st[k] = 1; end
                else st[k] = 0;
            end else if (le_i[k] && rise) begin
                cnt[k] = (cnt[k] < MAXC) ? cnt[k] + 1 : MAXC;
            end
            if (!le_i[k]) cnt[k] = 0;
            prev[k] = src_i[k];
        end
    endtask

    function automatic logic [2*N-1:0] model_out();
        logic [N-1:0] ip, ia;
        for (int k = 0; k < N; k++) begin ip[k] = (st[k] == 1); ia[k] = (st[k] == 2); end
        return {ip, ia};
    endfunction

    task automatic step();
        if (rst_ni) model_update();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(string name, logic [2*N-1:0] got, logic [2*N-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic op(bit cl, int cid, bit cp, int pid);
        claim_i = cl; claim_id_i = W'(cid);
        complete_i = cp; complete_id_i = W'(pid);
        step();
        claim_i = 1'b0; complete_i = 1'b0;
    endtask

    task automatic edge_run(string name, int pulses, int exp_repend);
        int n;
        src_i = '0; le_i = N'(1) << 5;
        step();
        src_i[5] = 1'b1; step(); src_i[5] = 1'b0;
        check({name, "_pend"}, 2*N'(ip_o[5]), 2*N'(1));
        op(1, 5, 0, 0);
        check({name, "_claim"}, 2*N'({ip_o[5], ia_o[5]}), 2*N'(1));
        repeat (pulses) begin src_i[5] = 1'b1; step(); src_i[5] = 1'b0; step(); end
        n = 0;
        for (int i = 0; i < 40; i++) begin
            op(0, 0, 1, 5);
            if (!ip_o[5]) break;
            n++;
            op(1, 5, 0, 0);
        end
        check({name, "_repends"}, 2*N'(n), 2*N'(exp_repend));
        check({name, "_idle"}, {ip_o, ia_o}, '0);
    endtask

    initial begin
        vecs[0]  = mk(1 << 3, 0, 0,  0, 0, 1 << 3, 0);
        vecs[1]  = mk(1 << 3, 1, 3,  0, 0, 0, 1 << 3);
        vecs[2]  = mk(1 << 3, 0, 0,  1, 3, 1 << 3, 0);
        vecs[3]  = mk(0,      1, 7,  0, 0, 1 << 3, 0);
        vecs[4]  = mk(0,      1, N,  0, 0, 1 << 3, 0);
        vecs[5]  = mk(1 << 7, 0, 0,  0, 0, (1 << 3) | (1 << 7), 0);
        vecs[6]  = mk(0,      0, 0,  1, 7, (1 << 3) | (1 << 7), 0);
        vecs[7]  = mk(0,      1, 3,  0, 0, 1 << 7, 1 << 3);
        vecs[8]  = mk(0,      0, 0,  1, 3, 1 << 7, 0);
        vecs[9]  = mk(0,      1, 7,  1, 7, 0, 1 << 7);
        vecs[10] = mk(0,      0, 0,  1, 7, 0, 0);
        model_reset();

        repeat (2) begin src_i = ~src_i; step(); end
        check("reset_hold", {ip_o, ia_o}, '0);
        src_i = '0;
        step();
        rst_ni = 1'b1;
        repeat (3) step();
        check("reset_release", {ip_o, ia_o}, '0);

        for (int i = 0; i < 11; i++) begin
            src_i = vecs[i].src;
            op(vecs[i].cl, vecs[i].cl_id, vecs[i].cp, vecs[i].cp_id);
            check($sformatf("vec%0d", i), {ip_o, ia_o}, {vecs[i].ip, vecs[i].ia});
        end

        edge_run("edge3", 3, (MAXC == 1) ? 1 : 3);
        edge_run("edge20", 20, MAXC);

        le_i = '0;
        src_i = N'(6);
        step();
        src_i = '0;
        check("sim_pend", {ip_o, ia_o}, {N'(6), N'(0)});
        op(1, 2, 0, 0);
        op(1, 1, 1, 2);
        check("sim_claim_complete", {ip_o, ia_o}, {N'(0), N'(2)});
        op(0, 0, 1, 1);
        src_i = N'(4); step(); src_i = '0;
        op(1, 2, 0, 0);
        check("pre_reset_active", {ip_o, ia_o}, {N'(0), N'(4)});
        #2 rst_ni = 1'b0;
        model_reset();
        #1;
        check("async_reset", {ip_o, ia_o}, '0);
        step();
        rst_ni = 1'b1;
        step();
        check("post_reset", {ip_o, ia_o}, '0);

        for (int i = 0; i < 1500; i++) begin
            le_i = (i % 200 < 100) ? N'($urandom) : le_i;
            src_i = N'($urandom) & N'($urandom);
            claim_i = 1'($urandom_range(0, 1));
            claim_id_i = W'($urandom_range(0, N + 1));
            complete_i = 1'($urandom_range(0, 1));
            complete_id_i = W'($urandom_range(0, N + 1));
            step();
            check($sformatf("rand%0d", i), {ip_o, ia_o}, model_out());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
